// File: rtl/outbuf_req_arbiter_pkg.sv
// Shared constants, bank beat packet and arbiter state encoding for the
// output-buffer write-back arbiter.
package outbuf_req_arbiter_pkg;

    localparam int NUM_BANKS  = 4;
    localparam int FV_W       = 16;
    localparam int MAX_FV_NUM = 16;
    localparam int NODE_W     = 8;

    localparam int BEATS  = MAX_FV_NUM / 2;
    localparam int BIDX_W = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam int BANK_W = (NUM_BANKS > 1) ? $clog2(NUM_BANKS) : 1;
    localparam int ADDR_W = NODE_W + BIDX_W;

    // One past the last legal beat index; a beat arriving here overflows the node slot
    localparam logic [BIDX_W:0] BEAT_LIM = (BIDX_W + 1)'(BEATS);

    typedef struct packed {
        logic                   gvalid;
        logic                   sos;
        logic                   eos;
        logic [NODE_W-1:0]      nodeid;
        logic [1:0][FV_W-1:0]   data;
    } beat_t;

    typedef enum logic [1:0] {
        ST_ARB    = 2'd0,
        ST_GRANT  = 2'd1,
        ST_STREAM = 2'd2
    } arb_state_e;

endpackage

// File: rtl/outbuf_req_arbiter_if.sv
// Bank-buffer request bus and output-SRAM write port of the write-back arbiter.
// master = bank buffers / SRAM side, slave = arbiter.
interface outbuf_req_arbiter_if;
    import outbuf_req_arbiter_pkg::*;

    logic [NUM_BANKS-1:0]               bank_req;
    logic [NUM_BANKS-1:0]               bank_gvalid;
    logic [NUM_BANKS-1:0]               bank_sos;
    logic [NUM_BANKS-1:0]               bank_eos;
    logic [NUM_BANKS-1:0][NODE_W-1:0]   bank_nodeid;
    logic [NUM_BANKS-1:0][2*FV_W-1:0]   bank_data;
    logic [NUM_BANKS-1:0]               req_grant;
    logic                               sram_we;
    logic [ADDR_W-1:0]                  sram_addr;
    logic [2*FV_W-1:0]                  sram_wdata;
    logic                               wb_done;
    logic [NODE_W-1:0]                  wb_nodeid;
    logic                               proto_err;

    modport master (
        output bank_req, bank_gvalid, bank_sos, bank_eos, bank_nodeid, bank_data,
        input  req_grant, sram_we, sram_addr, sram_wdata, wb_done, wb_nodeid, proto_err
    );

    modport slave (
        input  bank_req, bank_gvalid, bank_sos, bank_eos, bank_nodeid, bank_data,
        output req_grant, sram_we, sram_addr, sram_wdata, wb_done, wb_nodeid, proto_err
    );

endinterface

// File: rtl/outbuf_req_arbiter_rr_arbiter.sv
// Combinational round-robin pick: first requester at or after i_ptr, wrapping.
module rr_arbiter #(
    parameter int N = 4,
    parameter int W = 2
) (
    input  logic [N-1:0] i_req,
    input  logic [W-1:0] i_ptr,
    output logic [N-1:0] o_gnt,
    output logic [W-1:0] o_idx
);

    logic [W-1:0] w_cand;

    // Scan farthest-first so the nearest requester to the pointer is the last write
    always_comb begin
        o_gnt  = '0;
        o_idx  = '0;
        w_cand = '0;
        for (int k = N - 1; k >= 0; k--) begin
            w_cand = W'((int'(i_ptr) + k) % N);
            if (i_req[w_cand]) begin
                o_gnt         = '0;
                o_gnt[w_cand] = 1'b1;
                o_idx         = w_cand;
            end
        end
    end

endmodule

// File: rtl/outbuf_req_arbiter.sv
// Round-robin write-back arbiter: grants one bank, streams its beats into the
// output SRAM at {nodeid, beat_idx}. Optional OUTBUF_PERF_CNT_EN adds per-bank stream counters.
module outbuf_req_arbiter
    import outbuf_req_arbiter_pkg::*;
(
    input  logic                        clk,
    input  logic                        reset,
    outbuf_req_arbiter_if.slave         ob
`ifdef OUTBUF_PERF_CNT_EN
    ,
    output logic [NUM_BANKS-1:0][15:0]  o_perf_streams
`endif
);

    arb_state_e                 r_state, w_state_nxt;
    logic [BANK_W-1:0]          r_ptr, r_win, w_gidx;
    logic [NUM_BANKS-1:0]       w_gnt, r_grant;
    logic [BIDX_W:0]            r_bidx, w_bidx_cur;
    logic [NODE_W-1:0]          r_node, w_node_cur, r_wb_node;
    logic                       r_we, r_done, r_perr;
    logic [ADDR_W-1:0]          r_addr;
    logic [2*FV_W-1:0]          r_wdata;
    logic                       w_launch, w_cap, w_last, w_err;
    beat_t                      w_beat;

    rr_arbiter #(.N(NUM_BANKS), .W(BANK_W)) u_rr (
        .i_req (ob.bank_req),
        .i_ptr (r_ptr),
        .o_gnt (w_gnt),
        .o_idx (w_gidx)
    );

    always_comb begin
        w_beat.gvalid = ob.bank_gvalid[r_win];
        w_beat.sos    = ob.bank_sos[r_win];
        w_beat.eos    = ob.bank_eos[r_win];
        w_beat.nodeid = ob.bank_nodeid[r_win];
        w_beat.data   = ob.bank_data[r_win];
    end

    // The GRANT-cycle beat is always index 0 and carries the node id to latch
    assign w_bidx_cur = (r_state == ST_GRANT) ? '0 : r_bidx;
    assign w_node_cur = (r_state == ST_GRANT) ? w_beat.nodeid : r_node;

    always_ff @(posedge clk) begin
        if (!reset) r_state <= ST_ARB;
        else        r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        w_launch    = 1'b0;
        w_cap       = 1'b0;
        w_last      = 1'b0;
        w_err       = 1'b0;
        unique case (r_state)
            ST_ARB: begin
                if (|ob.bank_req) begin
                    w_launch    = 1'b1;
                    w_state_nxt = ST_GRANT;
                end
            end
            ST_GRANT: begin
                if (w_beat.gvalid && w_beat.sos) begin
                    w_cap       = 1'b1;
                    w_last      = w_beat.eos;
                    w_state_nxt = w_beat.eos ? ST_ARB : ST_STREAM;
                end else begin
                    w_err       = 1'b1;
                    w_state_nxt = ST_ARB;
                end
            end
            ST_STREAM: begin
                if (w_beat.gvalid) begin
                    if (w_beat.sos || (r_bidx >= BEAT_LIM)) begin
                        w_err       = 1'b1;
                        w_state_nxt = ST_ARB;
                    end else begin
                        w_cap       = 1'b1;
                        w_last      = w_beat.eos;
                        w_state_nxt = w_beat.eos ? ST_ARB : ST_STREAM;
                    end
                end
            end
            default: w_state_nxt = ST_ARB;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_ptr     <= '0;
            r_win     <= '0;
            r_grant   <= '0;
            r_bidx    <= '0;
            r_node    <= '0;
            r_we      <= 1'b0;
            r_addr    <= '0;
            r_wdata   <= '0;
            r_done    <= 1'b0;
            r_wb_node <= '0;
            r_perr    <= 1'b0;
        end else begin
            r_grant <= '0;
            r_we    <= 1'b0;
            r_done  <= 1'b0;
            if (w_launch) begin
                r_win   <= w_gidx;
                r_ptr   <= (w_gidx == BANK_W'(NUM_BANKS - 1)) ? '0 : w_gidx + 1'b1;
                r_grant <= w_gnt;
            end
            if (r_state == ST_GRANT) r_node <= w_beat.nodeid;
            if (w_err) r_perr <= 1'b1;
            if (w_cap) begin
                r_we    <= 1'b1;
                r_addr  <= {w_node_cur, w_bidx_cur[BIDX_W-1:0]};
                r_wdata <= w_beat.data;
                r_bidx  <= w_bidx_cur + 1'b1;
            end
            if (w_last) begin
                r_done    <= 1'b1;
                r_wb_node <= w_node_cur;
            end
        end
    end

    assign ob.req_grant  = r_grant;
    assign ob.sram_we    = r_we;
    assign ob.sram_addr  = r_addr;
    assign ob.sram_wdata = r_wdata;
    assign ob.wb_done    = r_done;
    assign ob.wb_nodeid  = r_wb_node;
    assign ob.proto_err  = r_perr;

`ifdef OUTBUF_PERF_CNT_EN
    logic [NUM_BANKS-1:0][15:0] r_perf;

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_perf <= '0;
        end else if (w_last && (r_perf[r_win] != 16'hFFFF)) begin
            r_perf[r_win] <= r_perf[r_win] + 16'd1;
        end
    end

    assign o_perf_streams = r_perf;
`endif

endmodule

// File: tb/tb_outbuf_req_arbiter.sv
// Scoreboard bench for outbuf_req_arbiter: stimulus pushes expected grants and
// SRAM writes, a negedge monitor pops and compares them.
module tb_outbuf_req_arbiter;
    import outbuf_req_arbiter_pkg::*;

    typedef struct {
        logic [ADDR_W-1:0]  addr;
        logic [2*FV_W-1:0]  data;
        logic               done;
        logic [NODE_W-1:0]  node;
    } exp_t;

    logic clk;
    logic reset;
    int   n_cmp;
    int   n_err;
    bit   mon_en;
    exp_t exp_q[$];
    int   exp_g[$];
    exp_t m_e;
    int   m_g;

    outbuf_req_arbiter_if bif ();

`ifdef OUTBUF_PERF_CNT_EN
    logic [NUM_BANKS-1:0][15:0] perf_streams;
`endif

    outbuf_req_arbiter dut (
        .clk   (clk),
        .reset (reset),
        .ob    (bif.slave)
`ifdef OUTBUF_PERF_CNT_EN
        ,
        .o_perf_streams (perf_streams)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic fail_now(input string nm);
        n_cmp++;
        n_err++;
        $display("FAIL %s", nm);
    endtask

    function automatic logic [2*FV_W-1:0] dpat(input int b, input int node, input int i);
        return {4'hA, 4'(b), 8'(node), 8'(i), 8'h5C};
    endfunction

    function automatic logic [ADDR_W-1:0] apat(input int node, input int i);
        return {NODE_W'(node), BIDX_W'(i)};
    endfunction

    // Monitor: every write and grant the DUT shows must match the next queued expectation
    always @(negedge clk) begin
        if (mon_en) begin
            if (bif.sram_we === 1'b1) begin
                if (exp_q.size() == 0) begin
                    fail_now($sformatf("unexpected_write addr %0h data %0h", bif.sram_addr, bif.sram_wdata));
                end else begin
                    m_e = exp_q.pop_front();
                    chk("sram_addr", 64'(bif.sram_addr), 64'(m_e.addr));
                    chk("sram_wdata", 64'(bif.sram_wdata), 64'(m_e.data));
                    chk("wb_done", 64'(bif.wb_done), 64'(m_e.done));
                    if (m_e.done) chk("wb_nodeid", 64'(bif.wb_nodeid), 64'(m_e.node));
                end
            end else if (bif.wb_done !== 1'b0) begin
                fail_now("stray_wb_done");
            end
            if (bif.req_grant !== '0) begin
                if (exp_g.size() == 0) begin
                    fail_now($sformatf("unexpected_grant %0h", bif.req_grant));
                end else begin
                    m_g = exp_g.pop_front();
                    chk("req_grant", 64'(bif.req_grant), 64'd1 << m_g);
                end
            end
        end
    end

    task automatic clear_bank(input int b);
        bif.bank_gvalid[b] = 1'b0;
        bif.bank_sos[b]    = 1'b0;
        bif.bank_eos[b]    = 1'b0;
        bif.bank_nodeid[b] = '0;
        bif.bank_data[b]   = '0;
    endtask

    task automatic drive_beat(input int b, input int node, input int i, input bit sos, input bit eos);
        bif.bank_gvalid[b] = 1'b1;
        bif.bank_sos[b]    = sos;
        bif.bank_eos[b]    = eos;
        bif.bank_nodeid[b] = NODE_W'(node);
        bif.bank_data[b]   = dpat(b, node, i);
    endtask

    task automatic wait_grant(input int b, output bit got);
        got = 1'b0;
        for (int c = 0; c < 30 && !got; c++) begin
            @(posedge clk); #1;
            if (bif.req_grant[b] === 1'b1) got = 1'b1;
        end
        if (!got) fail_now($sformatf("grant_timeout bank %0d", b));
    endtask

    // Request, wait for grant, then stream nbeats; only the first n_exp beats are expected to land
    task automatic run_stream(input int b, input int node, input int nbeats, input int gap_after,
                              input int gap_len, input bit sos_first, input int n_exp);
        bit got;
        exp_g.push_back(b);
        bif.bank_req[b] = 1'b1;
        wait_grant(b, got);
        bif.bank_req[b] = 1'b0;
        if (got) begin
            for (int i = 0; i < nbeats; i++) begin
                drive_beat(b, node, i, (i == 0) && sos_first, i == nbeats - 1);
                if (i < n_exp)
                    exp_q.push_back('{apat(node, i), dpat(b, node, i),
                                      (i == nbeats - 1) && (n_exp == nbeats), NODE_W'(node)});
                @(posedge clk); #1;
                if (i == gap_after) begin
                    bif.bank_gvalid[b] = 1'b0;
                    repeat (gap_len) begin @(posedge clk); #1; end
                end
            end
        end
        clear_bank(b);
    endtask

    // Serve whichever bank is granted next with a single sos&eos beat
    task automatic serve_one(input int node_base);
        int g;
        bit got;
        g = 0;
        got = 1'b0;
        for (int c = 0; c < 30 && !got; c++) begin
            @(posedge clk); #1;
            for (int k = 0; k < NUM_BANKS; k++)
                if (bif.req_grant[k] === 1'b1) begin g = k; got = 1'b1; end
        end
        if (!got) begin
            fail_now("grant_timeout any bank");
        end else begin
            drive_beat(g, node_base + g, 0, 1'b1, 1'b1);
            exp_q.push_back('{apat(node_base + g, 0), dpat(g, node_base + g, 0), 1'b1,
                              NODE_W'(node_base + g)});
            @(posedge clk); #1;
            clear_bank(g);
            bif.bank_req[g] = 1'b0;
        end
    endtask

    task automatic chk_outputs_zero(input string tag);
        chk({tag, "_sram_we"},    64'(bif.sram_we), 64'd0);
        chk({tag, "_req_grant"},  64'(bif.req_grant), 64'd0);
        chk({tag, "_sram_addr"},  64'(bif.sram_addr), 64'd0);
        chk({tag, "_sram_wdata"}, 64'(bif.sram_wdata), 64'd0);
        chk({tag, "_wb_done"},    64'(bif.wb_done), 64'd0);
        chk({tag, "_wb_nodeid"},  64'(bif.wb_nodeid), 64'd0);
        chk({tag, "_proto_err"},  64'(bif.proto_err), 64'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog_timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        bit got;
        n_cmp  = 0;
        n_err  = 0;
        mon_en = 1'b0;
        reset  = 1'b0;
        bif.bank_req    = '0;
        bif.bank_gvalid = '0;
        bif.bank_sos    = '0;
        bif.bank_eos    = '0;
        bif.bank_nodeid = '0;
        bif.bank_data   = '0;
        repeat (2) @(posedge clk);
        #1;
        chk_outputs_zero("reset");
        mon_en = 1'b1;
        reset  = 1'b1;
        @(posedge clk); #1;

        // Banks 0,2,3 from rr_ptr=0; bank 0 re-requests after its turn -> 0,2,3,0
        exp_g.push_back(0); exp_g.push_back(2); exp_g.push_back(3); exp_g.push_back(0);
        bif.bank_req[0] = 1'b1; bif.bank_req[2] = 1'b1; bif.bank_req[3] = 1'b1;
        serve_one(8'h10);
        bif.bank_req[0] = 1'b1;
        serve_one(8'h10);
        serve_one(8'h10);
        serve_one(8'h10);
        @(posedge clk); #1;

        // Bank 1, node 5, four beats
        run_stream(1, 5, 4, -1, 0, 1'b1, 4);
        @(posedge clk); #1;

        // Single-beat stream, node 9
        run_stream(3, 9, 1, -1, 0, 1'b1, 1);
        @(posedge clk); #1;

        // Three-cycle gvalid gap after beat 1
        run_stream(2, 7, 5, 1, 3, 1'b1, 5);
        repeat (2) @(posedge clk); #1;
        chk("gap_proto_err", 64'(bif.proto_err), 64'd0);

        // Missing sos in the grant cycle
        run_stream(0, 6, 1, -1, 0, 1'b0, 0);
        repeat (2) @(posedge clk); #1;
        chk("nosos_proto_err", 64'(bif.proto_err), 64'd1);

        reset = 1'b0;
        repeat (2) @(posedge clk); #1;
        chk("reset_clears_proto_err", 64'(bif.proto_err), 64'd0);
        reset = 1'b1;
        @(posedge clk); #1;

        // Nine beats against an eight-beat slot: eight writes, no done, then abort
        run_stream(1, 3, 9, -1, 0, 1'b1, 8);
        repeat (2) @(posedge clk); #1;
        chk("overflow_proto_err", 64'(bif.proto_err), 64'd1);
        reset = 1'b0;
        repeat (2) @(posedge clk); #1;
        reset = 1'b1;
        @(posedge clk); #1;

        // Reset after two beats of a stream from bank 2 (rr_ptr becomes 3)
        exp_g.push_back(2);
        bif.bank_req[2] = 1'b1;
        wait_grant(2, got);
        bif.bank_req[2] = 1'b0;
        for (int i = 0; i < 2; i++) begin
            drive_beat(2, 4, i, i == 0, 1'b0);
            exp_q.push_back('{apat(4, i), dpat(2, 4, i), 1'b0, 8'd4});
            @(posedge clk); #1;
        end
        drive_beat(2, 4, 2, 1'b0, 1'b0);
        reset = 1'b0;
        @(posedge clk); #1;
        chk_outputs_zero("midstream_reset");
        clear_bank(2);
        @(posedge clk); #1;
        reset = 1'b1;

        // rr_ptr back at 0: banks 0 and 3 requesting -> 0 first
        exp_g.push_back(0); exp_g.push_back(3);
        bif.bank_req[0] = 1'b1; bif.bank_req[3] = 1'b1;
        serve_one(8'h40);
        serve_one(8'h40);

        repeat (5) @(posedge clk); #1;
        chk("writes_outstanding", 64'(exp_q.size()), 64'd0);
        chk("grants_outstanding", 64'(exp_g.size()), 64'd0);
        chk("final_proto_err", 64'(bif.proto_err), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
